// File: rtl/risc_spm_control_unit_if.sv
// Control/datapath boundary of the RISC_SPM processor.
// The master modport is the control unit. The slave modport is the datapath, which supplies IR and Reg_Z.
interface risc_spm_control_unit_if;
  logic [7:0] instruction;
  logic       zero;
  logic       Load_R0;
  logic       Load_R1;
  logic       Load_R2;
  logic       Load_R3;
  logic       Load_PC;
  logic       Inc_PC;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_IR;
  logic       Load_Add_R;
  logic       Load_Reg_Y;
  logic       Load_Reg_Z;
  logic       write;
  logic       halted;

  modport master (
    input  instruction, zero,
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
           Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, write, halted
  );

  modport slave (
    output instruction, zero,
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
           Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, write, halted
  );
endinterface

// File: rtl/risc_spm_control_unit.sv
// RISC_SPM fetch/decode/execute sequencer; outputs decode combinationally from state and IR.
// 3 to 5 cycles per instruction from FET1 to FET1; no backpressure, and HALT holds until rst.
module risc_spm_control_unit #(
  parameter int         WORD   = 8,
  parameter logic [3:0] OP_NOP = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  risc_spm_control_unit_if.master bus
);
  localparam logic [3:0] OP_ADD = OP_NOP + 4'd1;
  localparam logic [3:0] OP_SUB = OP_NOP + 4'd2;
  localparam logic [3:0] OP_AND = OP_NOP + 4'd3;
  localparam logic [3:0] OP_NOT = OP_NOP + 4'd4;
  localparam logic [3:0] OP_RD  = OP_NOP + 4'd5;
  localparam logic [3:0] OP_WR  = OP_NOP + 4'd6;
  localparam logic [3:0] OP_BR  = OP_NOP + 4'd7;
  localparam logic [3:0] OP_BRZ = OP_NOP + 4'd8;

  localparam logic [2:0] SEL1_PC   = 3'd4;
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,  S_FET1 = 4'd1, S_FET2 = 4'd2, S_DEC = 4'd3,
    S_EX1  = 4'd4,  S_RD1  = 4'd5, S_RD2  = 4'd6, S_WR1 = 4'd7,
    S_WR2  = 4'd8,  S_BR1  = 4'd9, S_BR2  = 4'd10, S_HALT = 4'd11
  } state_t;

  state_t     state;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;
  logic [3:0] ld_r;

  assign opcode = bus.instruction[WORD-1 -: 4];
  assign src    = bus.instruction[3:2];
  assign dest   = bus.instruction[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: state <= S_FET1;
        S_FET1: state <= S_FET2;
        S_FET2: state <= S_DEC;
        S_DEC: begin
          case (opcode)
            OP_NOP, OP_NOT:         state <= S_FET1;
            OP_ADD, OP_SUB, OP_AND: state <= S_EX1;
            OP_RD:                  state <= S_RD1;
            OP_WR:                  state <= S_WR1;
            OP_BR:                  state <= S_BR1;
            OP_BRZ:                 state <= bus.zero ? S_BR1 : S_FET1;
            default:                state <= S_HALT;
          endcase
        end
        S_EX1:  state <= S_FET1;
        S_RD1:  state <= S_RD2;
        S_RD2:  state <= S_FET1;
        S_WR1:  state <= S_WR2;
        S_WR2:  state <= S_FET1;
        S_BR1:  state <= S_BR2;
        S_BR2:  state <= S_FET1;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_r              = 4'b0000;
    bus.Load_PC       = 1'b0;
    bus.Inc_PC        = 1'b0;
    bus.Sel_Bus_1_Mux = 3'd0;
    bus.Sel_Bus_2_Mux = 2'd0;
    bus.Load_IR       = 1'b0;
    bus.Load_Add_R    = 1'b0;
    bus.Load_Reg_Y    = 1'b0;
    bus.Load_Reg_Z    = 1'b0;
    bus.write         = 1'b0;
    bus.halted        = 1'b0;
    case (state)
      S_FET1: begin
        bus.Sel_Bus_1_Mux = SEL1_PC;
        bus.Sel_Bus_2_Mux = SEL2_BUS1;
        bus.Load_Add_R    = 1'b1;
      end
      S_FET2: begin
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        bus.Load_IR       = 1'b1;
        bus.Inc_PC        = 1'b1;
      end
      S_DEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            bus.Sel_Bus_1_Mux = {1'b0, src};
            bus.Sel_Bus_2_Mux = SEL2_BUS1;
            bus.Load_Reg_Y    = 1'b1;
          end
          OP_NOT: begin
            bus.Sel_Bus_1_Mux = {1'b0, src};
            bus.Sel_Bus_2_Mux = SEL2_ALU;
            bus.Load_Reg_Z    = 1'b1;
            ld_r[dest]        = 1'b1;
          end
          OP_RD, OP_WR, OP_BR: begin
            bus.Sel_Bus_1_Mux = SEL1_PC;
            bus.Sel_Bus_2_Mux = SEL2_BUS1;
            bus.Load_Add_R    = 1'b1;
          end
          OP_BRZ: begin
            // Not taken: step PC past the branch-target byte.
            if (bus.zero) begin
              bus.Sel_Bus_1_Mux = SEL1_PC;
              bus.Sel_Bus_2_Mux = SEL2_BUS1;
              bus.Load_Add_R    = 1'b1;
            end else begin
              bus.Inc_PC = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        bus.Sel_Bus_1_Mux = {1'b0, dest};
        bus.Sel_Bus_2_Mux = SEL2_ALU;
        bus.Load_Reg_Z    = 1'b1;
        ld_r[dest]        = 1'b1;
      end
      S_RD1, S_WR1: begin
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        bus.Load_Add_R    = 1'b1;
        bus.Inc_PC        = 1'b1;
      end
      S_RD2: begin
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        ld_r[dest]        = 1'b1;
      end
      S_WR2: begin
        bus.Sel_Bus_1_Mux = {1'b0, src};
        bus.write         = 1'b1;
      end
      S_BR1: begin
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        bus.Load_Add_R    = 1'b1;
      end
      S_BR2: begin
        bus.Sel_Bus_2_Mux = SEL2_MEM;
        bus.Load_PC       = 1'b1;
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.Load_R0 = ld_r[0];
  assign bus.Load_R1 = ld_r[1];
  assign bus.Load_R2 = ld_r[2];
  assign bus.Load_R3 = ld_r[3];
endmodule

// File: tb/tb_risc_spm_control_unit.sv
// Bench for risc_spm_control_unit: per-cycle expected output vectors are queued per instruction and compared as the FSM steps.
module tb_risc_spm_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [16:0] exp_q[$];

  risc_spm_control_unit_if bus();

  risc_spm_control_unit #(.WORD(8), .OP_NOP(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {R3,R2,R1,R0, Load_PC, Inc_PC, Sel1[2:0], Sel2[1:0], Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted}
  logic [16:0] obs;
  assign obs = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0, bus.Load_PC, bus.Inc_PC,
                bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux, bus.Load_IR, bus.Load_Add_R,
                bus.Load_Reg_Y, bus.Load_Reg_Z, bus.write, bus.halted};

  function automatic logic [16:0] ov(input logic [3:0] ldr, input logic ld_pc, input logic inc_pc,
                                     input logic [2:0] s1, input logic [1:0] s2, input logic ld_ir,
                                     input logic ld_ar, input logic ld_y, input logic ld_z,
                                     input logic wr, input logic hlt);
    return {ldr, ld_pc, inc_pc, s1, s2, ld_ir, ld_ar, ld_y, ld_z, wr, hlt};
  endfunction

  task automatic check_val(input string tag, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Compare every queued cycle, checking the invariants on the same cycle, then advance the clock.
  task automatic drain(input string tag);
    logic [16:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(tag, obs, e);
      check_val("inv_one_load_r",
                {16'd0, $countones({bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0}) <= 1}, 17'd1);
      check_val("inv_pc", {16'd0, bus.Load_PC & bus.Inc_PC}, 17'd0);
      check_val("inv_write",
                {16'd0, bus.write & (bus.Load_R0 | bus.Load_R1 | bus.Load_R2 | bus.Load_R3 |
                 bus.Load_PC | bus.Load_IR | bus.Load_Add_R | bus.Load_Reg_Y | bus.Load_Reg_Z)}, 17'd0);
      @(posedge clk);
      #1;
    end
  endtask

  logic [16:0] fet1, fet2, rdwr1, br1, br2;

  task automatic push_fetch(input logic [7:0] instr, input logic z);
    bus.instruction = instr;
    bus.zero        = z;
    exp_q.push_back(fet1);
    exp_q.push_back(fet2);
  endtask

  task automatic alu_op(input string tag, input logic [7:0] instr);
    logic [3:0] d1h;
    d1h = 4'b0001 << instr[1:0];
    push_fetch(instr, 1'b0);
    exp_q.push_back(ov(4'b0, 0, 0, {1'b0, instr[3:2]}, 2'd1, 0, 0, 1, 0, 0, 0));
    exp_q.push_back(ov(d1h, 0, 0, {1'b0, instr[1:0]}, 2'd0, 0, 0, 0, 1, 0, 0));
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    fet1  = ov(4'b0, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
    fet2  = ov(4'b0, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0);
    rdwr1 = ov(4'b0, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0);
    br1   = ov(4'b0, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0);
    br2   = ov(4'b0, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0);
    bus.instruction = 8'h00;
    bus.zero        = 1'b0;

    // Reset held two clocks, then one IDLE cycle with all outputs low.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(17'd0);
    drain("reset_idle");

    alu_op("add_16", 8'h16);
    alu_op("sub_2d", 8'h2D);
    alu_op("and_30", 8'h30);

    push_fetch(8'h00, 1'b0);
    exp_q.push_back(17'd0);
    drain("nop");

    push_fetch(8'h47, 1'b0);
    exp_q.push_back(ov(4'b1000, 0, 0, 3'd1, 2'd0, 0, 0, 0, 1, 0, 0));
    drain("not_47");

    push_fetch(8'h80, 1'b0);
    exp_q.push_back(ov(4'b0, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0));
    drain("brz_nt");

    push_fetch(8'h80, 1'b1);
    exp_q.push_back(fet1);
    exp_q.push_back(br1);
    exp_q.push_back(br2);
    drain("brz_t");

    push_fetch(8'h70, 1'b0);
    exp_q.push_back(fet1);
    exp_q.push_back(br1);
    exp_q.push_back(br2);
    drain("br");

    push_fetch(8'h5B, 1'b0);
    exp_q.push_back(fet1);
    exp_q.push_back(rdwr1);
    exp_q.push_back(ov(4'b1000, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));
    drain("rd_5b");

    push_fetch(8'h64, 1'b0);
    exp_q.push_back(fet1);
    exp_q.push_back(rdwr1);
    exp_q.push_back(ov(4'b0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 1, 0));
    drain("wr_64");

    // Undefined opcode: halt for 10 checked cycles, then rst back to IDLE.
    push_fetch(8'hF0, 1'b0);
    exp_q.push_back(17'd0);
    for (int i = 0; i < 10; i++) exp_q.push_back(ov(4'b0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1));
    drain("halt_f0");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(17'd0);
    drain("halt_rst");

    push_fetch(8'h9C, 1'b0);
    exp_q.push_back(17'd0);
    exp_q.push_back(ov(4'b0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1));
    drain("halt_9c");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(17'd0);
    drain("halt9_rst");

    // Reset during EX1 of an ADD.
    push_fetch(8'h16, 1'b0);
    exp_q.push_back(ov(4'b0, 0, 0, 3'd1, 2'd1, 0, 0, 1, 0, 0, 0));
    drain("ex1_pre");
    rst = 1'b1;
    exp_q.push_back(ov(4'b0100, 0, 0, 3'd2, 2'd0, 0, 0, 0, 1, 0, 0));
    drain("ex1_cut");
    rst = 1'b0;
    exp_q.push_back(17'd0);
    drain("ex1_idle");

    // Reset during WR2: the next cycle is IDLE and write is low.
    push_fetch(8'h64, 1'b0);
    exp_q.push_back(fet1);
    exp_q.push_back(rdwr1);
    drain("wr2_pre");
    rst = 1'b1;
    exp_q.push_back(ov(4'b0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 1, 0));
    drain("wr2_cut");
    rst = 1'b0;
    exp_q.push_back(17'd0);
    drain("wr2_idle");

    exp_q.push_back(fet1);
    drain("post_fet1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
